// File: rtl/text_pkg.sv
// Shared definitions for the text buffer controller: geometry defaults,
// fill/control codes, cursor glyph, FSM state encoding and address helpers.
package text_pkg;

   localparam int unsigned DEF_ROWS  = 7;
   localparam int unsigned DEF_COLS  = 20;
   localparam logic [7:0]  DEF_BLANK = 8'h20;

   localparam logic [7:0] CODE_BS = 8'h08;
   localparam logic [7:0] CODE_LF = 8'h0A;
   localparam logic [7:0] CODE_FF = 8'h0C;
   localparam logic [7:0] CODE_CR = 8'h0D;

   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   localparam logic [7:0] CURSOR_GLYPH = 8'h5F;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      CLEAR,
      SCROLL_RD,
      SCROLL_WR,
      SCROLL_FILL
   } state_t;

   // True for codes that are stored in the buffer as visible characters.
   function automatic logic is_printable(input logic [7:0] code);
      return (code >= PRINT_LO) && (code <= PRINT_HI);
   endfunction

   // Linear cell index row*cols+col, kept to 8 bits.
   function automatic logic [7:0] cell_addr(input logic [7:0] row,
                                            input logic [7:0] col,
                                            input logic [7:0] cols);
      logic [15:0] prod;
      prod = {8'b0, row} * {8'b0, cols};
      return prod[7:0] + col;
   endfunction

endpackage

// File: rtl/text_ram.sv
// Character cell store: port A is a synchronous read-only display port,
// port B a synchronous read/write port owned by the controller FSM.
module text_ram
   import text_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_ROWS * DEF_COLS
) (
   input  logic       clk,
   input  logic [7:0] addr_a,
   output logic [7:0] rdata_a,
   input  logic [7:0] addr_b,
   input  logic       we_b,
   input  logic [7:0] wdata_b,
   output logic [7:0] rdata_b
);

   logic [7:0] mem [DEPTH];

   // Display read port, one cycle latency, never stalled by port B.
   always_ff @(posedge clk) begin
      rdata_a <= mem[addr_a];
   end

   // Controller port: read-before-write, no reset on contents.
   always_ff @(posedge clk) begin
      if (we_b) begin
         mem[addr_b] <= wdata_b;
      end
      rdata_b <= mem[addr_b];
   end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Character-cell text buffer controller: accepts printable and control codes,
// maintains a cursor, scrolls and clears the buffer, and serves a display
// read port. Optional cursor blink overlay: define TEXT_CURSOR_BLINK_EN.
module text_buffer_ctrl
   import text_pkg::*;
#(
   parameter int unsigned ROWS  = DEF_ROWS,
   parameter int unsigned COLS  = DEF_COLS,
   parameter logic [7:0]  BLANK = DEF_BLANK
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   output logic       char_ready,
   input  logic       frame_tick,
   input  logic [3:0] rin,
   input  logic [5:0] cin,
   output logic [7:0] charout,
   output logic [2:0] cursor_row,
   output logic [4:0] cursor_col,
   output logic       busy
);

   localparam logic [7:0] LAST_CELL = 8'(ROWS * COLS - 1);
   localparam logic [7:0] LAST_COPY = 8'((ROWS - 1) * COLS - 1);
   localparam logic [7:0] COLS8     = 8'(COLS);
   localparam logic [2:0] LAST_ROW  = 3'(ROWS - 1);
   localparam logic [4:0] LAST_COL  = 5'(COLS - 1);

   state_t     state;
   state_t     next_state;
   logic [7:0] idx;
   logic [7:0] pend_char;
   logic       pend_adv;

   logic       accept;
   logic       is_nl;
   logic       at_origin;
   logic       at_last_cell;

   logic       ram_we;
   logic [7:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;

   logic       disp_oob;
   logic [7:0] disp_addr;
   logic [7:0] disp_data;
   logic       oob_q;
   logic       hit_q;
   logic       blink_phase;

   assign accept       = char_valid && char_ready;
   assign is_nl        = (char_data == CODE_LF) || (char_data == CODE_CR);
   assign at_origin    = (cursor_row == 3'd0) && (cursor_col == 5'd0);
   assign at_last_cell = (cursor_row == LAST_ROW) && (cursor_col == LAST_COL);

   // State register; reset lands in CLEAR so the buffer is wiped after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= CLEAR;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_printable(char_data)) begin
                  next_state = WRITE;
               end else if (char_data == CODE_BS) begin
                  if (!at_origin) next_state = WRITE;
               end else if (is_nl) begin
                  if (cursor_row == LAST_ROW) next_state = SCROLL_RD;
               end else if (char_data == CODE_FF) begin
                  next_state = CLEAR;
               end
            end
         end
         WRITE: begin
            if (pend_adv && at_last_cell) next_state = SCROLL_RD;
            else                          next_state = IDLE;
         end
         CLEAR: begin
            if (idx == LAST_CELL) next_state = IDLE;
         end
         SCROLL_RD: begin
            next_state = SCROLL_WR;
         end
         SCROLL_WR: begin
            if (idx == LAST_COPY) next_state = SCROLL_FILL;
            else                  next_state = SCROLL_RD;
         end
         SCROLL_FILL: begin
            if (idx == LAST_CELL) next_state = IDLE;
         end
         default: next_state = CLEAR;
      endcase
   end

   // Output decode: handshake, busy flag and RAM port B controls.
   always_comb begin
      char_ready = 1'b0;
      busy       = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = idx;
      ram_wdata  = BLANK;
      case (state)
         IDLE: begin
            char_ready = 1'b1;
         end
         WRITE: begin
            ram_we    = 1'b1;
            ram_addr  = cell_addr(8'(cursor_row), 8'(cursor_col), COLS8);
            ram_wdata = pend_char;
         end
         CLEAR: begin
            busy   = 1'b1;
            ram_we = 1'b1;
         end
         SCROLL_RD: begin
            busy     = 1'b1;
            ram_addr = idx + COLS8;
         end
         SCROLL_WR: begin
            busy      = 1'b1;
            ram_we    = 1'b1;
            ram_wdata = ram_rdata;
         end
         SCROLL_FILL: begin
            busy   = 1'b1;
            ram_we = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Cursor, sweep index and pending write; backspace moves the cursor on
   // acceptance so the WRITE cycle blanks the new position without advancing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cursor_row <= '0;
         cursor_col <= '0;
         idx        <= '0;
         pend_char  <= BLANK;
         pend_adv   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_printable(char_data)) begin
                     pend_char <= char_data;
                     pend_adv  <= 1'b1;
                  end else if (char_data == CODE_BS) begin
                     pend_char <= BLANK;
                     pend_adv  <= 1'b0;
                     if (cursor_col != 5'd0) begin
                        cursor_col <= cursor_col - 5'd1;
                     end else if (cursor_row != 3'd0) begin
                        cursor_row <= cursor_row - 3'd1;
                        cursor_col <= LAST_COL;
                     end
                  end else if (is_nl) begin
                     cursor_col <= '0;
                     if (cursor_row == LAST_ROW) idx <= '0;
                     else                        cursor_row <= cursor_row + 3'd1;
                  end else if (char_data == CODE_FF) begin
                     cursor_row <= '0;
                     cursor_col <= '0;
                     idx        <= '0;
                  end
               end
            end
            WRITE: begin
               if (pend_adv) begin
                  if (cursor_col == LAST_COL) begin
                     cursor_col <= '0;
                     if (cursor_row == LAST_ROW) idx <= '0;
                     else                        cursor_row <= cursor_row + 3'd1;
                  end else begin
                     cursor_col <= cursor_col + 5'd1;
                  end
               end
            end
            CLEAR, SCROLL_FILL: begin
               if (idx == LAST_CELL) idx <= '0;
               else                  idx <= idx + 8'd1;
            end
            SCROLL_WR: begin
               idx <= idx + 8'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign disp_oob  = (32'(rin) >= ROWS) || (32'(cin) >= COLS);
   assign disp_addr = disp_oob ? '0 : cell_addr(8'(rin), 8'(cin), COLS8);

   // Display-side flags aligned with the registered RAM read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         oob_q <= 1'b1;
         hit_q <= 1'b0;
      end else begin
         oob_q <= disp_oob;
         hit_q <= (rin == {1'b0, cursor_row}) && (cin == {1'b0, cursor_col});
      end
   end

`ifdef TEXT_CURSOR_BLINK_EN
   logic [4:0] frame_cnt;

   // Blink phase flips once every 32 frame ticks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_tick) begin
         frame_cnt <= frame_cnt + 5'd1;
         if (frame_cnt == 5'd31) blink_phase <= ~blink_phase;
      end
   end
`else
   logic unused_frame_tick;
   assign blink_phase       = 1'b0;
   assign unused_frame_tick = frame_tick;
`endif

   // Display output mux: blank outside the grid, optional cursor overlay.
   always_comb begin
      if (oob_q)                     charout = BLANK;
      else if (blink_phase && hit_q) charout = CURSOR_GLYPH;
      else                           charout = disp_data;
   end

   text_ram #(
      .DEPTH (ROWS * COLS)
   ) u_ram (
      .clk     (clk),
      .addr_a  (disp_addr),
      .rdata_a (disp_data),
      .addr_b  (ram_addr),
      .we_b    (ram_we),
      .wdata_b (ram_wdata),
      .rdata_b (ram_rdata)
   );

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed bench for text_buffer_ctrl at default geometry (7x20, blank 8'h20).
module tb_text_buffer_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       char_valid = 1'b0;
   logic [7:0] char_data = 8'h00;
   logic       char_ready;
   logic       frame_tick = 1'b0;
   logic [3:0] rin = 4'd0;
   logic [5:0] cin = 6'd0;
   logic [7:0] charout;
   logic [2:0] cursor_row;
   logic [4:0] cursor_col;
   logic       busy;

   int unsigned total  = 0;
   int unsigned passed = 0;

   always #5 clk = ~clk;

   text_buffer_ctrl #(
      .ROWS  (7),
      .COLS  (20),
      .BLANK (8'h20)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .frame_tick (frame_tick),
      .rin        (rin),
      .cin        (cin),
      .charout    (charout),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] pos(input int r, input int c);
      return {24'b0, 3'(r), 5'(c)};
   endfunction

   function automatic logic [31:0] cur();
      return {24'b0, cursor_row, cursor_col};
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!char_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!char_ready) check("ready_timeout", 32'(char_ready), 32'd1);
   endtask

   task automatic send(input logic [7:0] c);
      wait_ready();
      char_valid = 1'b1;
      char_data  = c;
      @(negedge clk);
      char_valid = 1'b0;
      char_data  = 8'h00;
   endtask

   task automatic busy_cycles(output int n);
      n = 0;
      while (busy && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic read_cell(input int r, input int c, output logic [7:0] v);
      rin = 4'(r);
      cin = 6'(c);
      @(negedge clk);
      v = charout;
   endtask

   task automatic count_bad(input int r, input int c0, input int c1,
                            input logic [7:0] exp, output int bad);
      logic [7:0] v;
      bad = 0;
      for (int c = c0; c <= c1; c++) begin
         read_cell(r, c, v);
         if (v !== exp) bad++;
      end
   endtask

   initial begin
      int n;
      int bad;
      int acc;
      logic [7:0] v;

      // Reset assertion takes effect immediately, without a clock edge.
      rin = 4'd0;
      cin = 6'd1;
      #3 reset = 1'b1;
      #1;
      check("rst_ready", 32'(char_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_cursor", cur(), pos(0, 0));
      check("rst_charout", 32'(charout), 32'h20);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      busy_cycles(n);
      check("rst_clear_cycles", 32'(n), 32'd140);
      check("rst_ready_after", 32'(char_ready), 32'd1);
      acc = 0;
      for (int r = 0; r < 7; r++) begin
         count_bad(r, 0, 19, 8'h20, bad);
         acc += bad;
      end
      check("rst_all_blank", 32'(acc), 32'd0);

      // "AB" then carriage return.
      send(8'h41);
      send(8'h42);
      wait_ready();
      check("ab_cursor", cur(), pos(0, 2));
      read_cell(0, 1, v);
      check("ab_cell01", 32'(v), 32'h42);
      read_cell(0, 0, v);
      check("ab_cell00", 32'(v), 32'h41);
      send(8'h0D);
      wait_ready();
      check("cr_cursor", cur(), pos(1, 0));

      // Form feed from mid-text.
      send(8'h0C);
      busy_cycles(n);
      check("ff_cycles", 32'(n), 32'd140);
      check("ff_cursor", cur(), pos(0, 0));
      read_cell(0, 0, v);
      check("ff_cell00", 32'(v), 32'h20);

      // Backspace at origin and an ignored code leave everything alone.
      send(8'h08);
      wait_ready();
      check("bs_origin_cursor", cur(), pos(0, 0));
      send(8'h01);
      wait_ready();
      check("ignored_cursor", cur(), pos(0, 0));

      // Row wrap then backspace across the row boundary.
      for (int i = 0; i < 20; i++) send(8'h41);
      wait_ready();
      check("wrap_cursor", cur(), pos(1, 0));
      send(8'h08);
      wait_ready();
      check("bs_wrap_cursor", cur(), pos(0, 19));
      read_cell(0, 19, v);
      check("bs_cell019", 32'(v), 32'h20);
      read_cell(0, 18, v);
      check("bs_cell018", 32'(v), 32'h41);

      // Fill rows 0-5 with digits, 19 cells of row 6, then newline scrolls.
      send(8'h0C);
      busy_cycles(n);
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 20; c++) send(8'(8'h30 + r));
      for (int c = 0; c < 19; c++) send(8'h36);
      wait_ready();
      check("pre_scroll_cursor", cur(), pos(6, 19));
      send(8'h0A);
      busy_cycles(n);
      check("scroll_cycles", 32'(n), 32'd260);
      check("scroll_cursor", cur(), pos(6, 0));
      count_bad(0, 0, 19, 8'h31, bad);
      check("scroll_row0", 32'(bad), 32'd0);
      count_bad(4, 0, 19, 8'h35, bad);
      check("scroll_row4", 32'(bad), 32'd0);
      read_cell(5, 0, v);
      check("scroll_cell50", 32'(v), 32'h36);
      read_cell(5, 19, v);
      check("scroll_cell519", 32'(v), 32'h20);
      count_bad(6, 0, 19, 8'h20, bad);
      check("scroll_row6", 32'(bad), 32'd0);

      // Out-of-grid display coordinates; (0,20) would alias cell (1,0)='2'.
      read_cell(7, 0, v);
      check("oob_row7", 32'(v), 32'h20);
      read_cell(0, 20, v);
      check("oob_col20", 32'(v), 32'h20);
      read_cell(1, 0, v);
      check("cell10", 32'(v), 32'h32);

      // Form feed after some text on the bottom row.
      send(8'h58);
      send(8'h59);
      send(8'h0C);
      busy_cycles(n);
      check("ff2_cycles", 32'(n), 32'd140);
      check("ff2_cursor", cur(), pos(0, 0));

      // Reset in the middle of a scroll.
      send(8'h51);
      send(8'h51);
      for (int i = 0; i < 6; i++) send(8'h0A);
      wait_ready();
      check("pre_scroll2_cursor", cur(), pos(6, 0));
      send(8'h0A);
      repeat (99) @(negedge clk);
      check("scroll2_busy", 32'(busy), 32'd1);
      rin = 4'd0;
      cin = 6'd0;
      reset = 1'b1;
      #1;
      check("midrst_ready", 32'(char_ready), 32'd0);
      check("midrst_busy", 32'(busy), 32'd1);
      check("midrst_cursor", cur(), pos(0, 0));
      check("midrst_charout", 32'(charout), 32'h20);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      busy_cycles(n);
      check("midrst_clear_cycles", 32'(n), 32'd140);
      check("midrst_ready_after", 32'(char_ready), 32'd1);
      acc = 0;
      for (int r = 0; r < 7; r++) begin
         count_bad(r, 0, 19, 8'h20, bad);
         acc += bad;
      end
      check("midrst_all_blank", 32'(acc), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/text_buffer_ctrl.md
TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 7, meaning text rows displayed.
REQ-002 SHALL have parameter COLS, default 20, meaning character columns per row.
REQ-003 SHALL have parameter BLANK, default 8'h20, meaning fill code for cleared cells.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port char_valid  input  1  writer presents a character code.
REQ-007 SHALL have port char_data  input  8  character or control code.
REQ-008 SHALL have port char_ready  output  1  controller accepts char_data this cycle.
REQ-009 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-010 SHALL have port rin  input  4  display row being rendered.
REQ-011 SHALL have port cin  input  6  display column being rendered.
REQ-012 SHALL have port charout  output  8  character code for (rin,cin).
REQ-013 SHALL have ports cursor_row  output  3 and cursor_col  output  5, both giving current write position.
REQ-014 SHALL have port busy  output  1  high while clearing or scrolling.

Function
REQ-015 SHALL transfer a character only in a cycle where char_valid and char_ready are both high; char_ready is high only in state IDLE.
REQ-016 SHALL use FSM states IDLE, WRITE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_FILL; busy = state in {CLEAR, SCROLL_*}.
REQ-017 SHALL, for an accepted code 8'h20-8'h7E, write it at cell cursor_row*COLS+cursor_col in WRITE (1 cycle), then advance cursor_col; col COLS-1 wraps to col 0 of the next row.
REQ-018 SHALL, when the advance or a newline leaves row ROWS-1, enter SCROLL_RD; the cursor moves to (ROWS-1, 0).
REQ-019 SHALL scroll by copying cell i+COLS to cell i for i = 0..(ROWS-1)*COLS-1, one read cycle (SCROLL_RD) then one write cycle (SCROLL_WR) per cell, then write BLANK to the last COLS cells (SCROLL_FILL); total 2*(ROWS-1)*COLS+COLS cycles (260 at defaults).
REQ-020 SHALL treat 8'h0D and 8'h0A identically as newline: cursor_col to 0, cursor_row+1 (scroll at bottom per REQ-018), no cell written.
REQ-021 SHALL treat 8'h08 as backspace: col>0 -> col-1 and write BLANK there; col=0,row>0 -> (row-1, COLS-1) and write BLANK; at (0,0) no write, no move.
REQ-022 SHALL treat 8'h0C as form feed: enter CLEAR, write BLANK to all ROWS*COLS cells in ascending order (140 cycles), cursor to (0,0).
REQ-023 SHALL consume and ignore all other codes (accepted, no write, no cursor change).
REQ-024 SHALL return charout registered, one cycle after rin/cin, from a dedicated read port independent of FSM state; display reads never stall.
REQ-025 SHALL return BLANK on charout when rin >= ROWS or cin >= COLS.
REQ-026 SHALL compute cell addresses as 8-bit unsigned values, never exceeding ROWS*COLS-1 for writes.
REQ-027 SHALL show during scroll or clear, on the display port, whatever the RAM holds at that cycle (tearing permitted).

Reset
REQ-028 SHALL, on reset assertion, immediately set cursor (0,0), char_ready 0, charout BLANK, busy 1, state CLEAR, clear index 0.
REQ-029 SHALL, after reset release, run a full CLEAR (REQ-022) before the first IDLE; RAM contents themselves are not reset.
REQ-030 SHALL, if reset asserts mid-scroll or mid-clear, abandon the operation and restart per REQ-028.

Configuration
REQ-031 SHALL, with macro TEXT_CURSOR_BLINK_EN defined, substitute 8'h5F on charout for the cursor cell while a blink phase bit is 1; the bit toggles every 32 frame_tick pulses and resets to 0.
REQ-032 SHALL, without TEXT_CURSOR_BLINK_EN, ignore frame_tick and show RAM contents only.

Structure
REQ-033 SHALL place ROWS/COLS defaults, BLANK, control codes (BS, LF, CR, FF), cursor glyph and the FSM state enum in shared package text_pkg.
REQ-034 SHALL instantiate one sub-module text_ram: ROWS*COLS x 8 dual-port RAM, port A synchronous read-only (display), port B synchronous read/write (controller).

Verification
REQ-035 SHALL check: reset then wait 140 cycles -> char_ready rises; all 140 cells read 8'h20.
REQ-036 SHALL check: send "AB" -> rin=0,cin=1 gives 8'h42 one cycle later; cursor (0,2).
REQ-037 SHALL check: send 20 x 8'h41 -> cursor (1,0); send 8'h08 -> cursor (0,19), cell (0,19)=8'h20.
REQ-038 SHALL check: fill rows 0-6 with row digit '0'-'6', send 8'h0A at row 6 -> busy 260 cycles, row 0 reads '1', row 6 blank, cursor (6,0).
REQ-039 SHALL check: rin=7 or cin=20 -> charout 8'h20; 8'h0C mid-text -> busy 140 cycles, cursor (0,0).
REQ-040 SHALL check: assert reset at scroll cycle 100 -> char_ready 0 at once, full CLEAR completes after release.
